// File: rtl/maskvect_writer.sv
// Write-side sequencer for the mask vector memories: one insert/delete request
// becomes a read-modify-write on the addressed entry of each of the NSEG mask memories.
module maskvect_writer #(
    parameter int KWID    = 104,
    parameter int SEGWID  = 10,
    parameter int NSEG    = KWID / 8,
    parameter int MASKWID = KWID / 8,
    parameter int VTWID   = SEGWID * NSEG
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_Req_Valid,
    output logic                      o_Req_Ready,
    input  logic                      i_Req_Op,
    input  logic [VTWID-1:0]          i_Req_Segments,
    input  logic [NSEG*MASKWID-1:0]   i_Req_Mask_Data,
    input  logic                      i_Search_Active,
    output logic [NSEG-1:0]           o_Mem_Sel,
    output logic [SEGWID-1:0]         o_Mem_Addr,
    output logic                      o_Mem_Rd_En,
    output logic                      o_Mem_Wr_En,
    output logic [MASKWID-1:0]        o_Mem_Wdata,
    input  logic [MASKWID-1:0]        i_Mem_Rdata,
    output logic                      o_Busy,
    output logic                      o_Done
);

    localparam int KBITS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state_q;
    logic [KBITS-1:0]          k_q;
    logic                      op_q;
    logic [VTWID-1:0]          seg_q;
    logic [NSEG*MASKWID-1:0]   mask_q;
    logic [MASKWID-1:0]        old_q;
    logic                      ready_q;
    logic                      busy_q;
    logic                      done_q;

    logic [MASKWID-1:0]        m_k;
    logic [SEGWID-1:0]         seg_k;
    logic [NSEG-1:0]           sel_oh;
    logic [MASKWID-1:0]        new_word;
    logic                      last_k;
    logic                      rd_fire;
    logic                      wr_fire;

    always_comb begin
        m_k      = mask_q[int'(k_q) * MASKWID +: MASKWID];
        seg_k    = seg_q[int'(k_q) * SEGWID +: SEGWID];
        sel_oh   = '0;
        sel_oh[k_q] = 1'b1;
        last_k   = (k_q == KBITS'(NSEG - 1));
        new_word = op_q ? (old_q & ~m_k) : (old_q | m_k);
        // The search path owns the ports this cycle: only the strobe is gated combinationally.
        rd_fire  = (state_q == S_READ) && (m_k != '0) && !i_Search_Active;
        wr_fire  = (state_q == S_WRITE) && !i_Search_Active;
    end

    always_comb begin
        o_Mem_Rd_En = rd_fire;
        o_Mem_Wr_En = wr_fire;
        o_Mem_Sel   = (rd_fire || wr_fire) ? sel_oh : '0;
        o_Mem_Addr  = (rd_fire || wr_fire) ? seg_k  : '0;
        o_Mem_Wdata = wr_fire ? new_word : '0;
        o_Req_Ready = ready_q;
        o_Busy      = busy_q;
        o_Done      = done_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            op_q    <= 1'b0;
            seg_q   <= '0;
            mask_q  <= '0;
            old_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_Req_Valid) begin
                        op_q    <= i_Req_Op;
                        seg_q   <= i_Req_Segments;
                        mask_q  <= i_Req_Mask_Data;
                        k_q     <= '0;
                        state_q <= S_READ;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (m_k == '0) begin
                        if (last_k) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            k_q <= k_q + KBITS'(1);
                        end
                    end else if (!i_Search_Active) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    old_q   <= i_Mem_Rdata;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (!i_Search_Active) begin
                        if (last_k) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            k_q     <= k_q + KBITS'(1);
                            state_q <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
